// File: rtl/addsub_seq_pkg.sv
// Shared definitions for the chunk-serial add/subtract unit.
//   st_e     : FSM state encoding (IDLE/RUN/DONE)
//   MODE_*   : mode select values (0 = subtract, 1 = add)
package addsub_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } st_e;

  localparam logic MODE_SUB = 1'b0;
  localparam logic MODE_ADD = 1'b1;

endpackage

// File: rtl/addsub_seq_chunk.sv
// Combinational CHUNK-bit add/subtract slice.
//   x, y      : operand slices
//   chain_in  : internal carry into the slice (for subtract this is the
//               inverted borrow, so the slice always computes x + y' + c)
//   mode      : MODE_ADD uses y, MODE_SUB uses ~y
//   s         : slice sum
//   chain_out : internal carry out of the slice
module addsub_chunk
  import addsub_seq_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             chain_in,
  input  logic             mode,
  output logic [CHUNK-1:0] s,
  output logic             chain_out
);

  logic [CHUNK-1:0] y_eff;
  logic [CHUNK:0]   sum;

  always_comb begin
    y_eff = (mode == MODE_ADD) ? y : ~y;
    sum   = {1'b0, x} + {1'b0, y_eff} + {{CHUNK{1'b0}}, chain_in};
  end

  assign s         = sum[CHUNK-1:0];
  assign chain_out = sum[CHUNK];

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle chunk-serial add/subtract unit. One CHUNK-bit slice per clock,
// LSB slice first, with the carry chained through a register.
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : operation handshake (a, b, cin, mode)
//   out_valid/out_ready  : result handshake (result, cout, zero, ovf)
//   cout                 : add -> carry-out, sub -> borrow-out
//   zero / ovf           : result == 0 / signed two's-complement overflow
module addsub_seq
  import addsub_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             ovf
);

  localparam int NCH  = WIDTH / CHUNK;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int MSB  = WIDTH - 1;

  generate
    if ((WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("addsub_seq: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  st_e              state_q,  state_d;
  logic [IDXW-1:0]  idx_q,    idx_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic             mode_q,   mode_d;
  logic             chain_q,  chain_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q,   cout_d;
  logic             zero_q,   zero_d;
  logic             ovf_q,    ovf_d;

  logic [CHUNK-1:0] x_sl, y_sl, s_sl;
  logic             chain_out;
  logic             last;

  assign x_sl = a_q[idx_q*CHUNK +: CHUNK];
  assign y_sl = b_q[idx_q*CHUNK +: CHUNK];
  assign last = (idx_q == IDXW'(NCH - 1));

  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x         (x_sl),
    .y         (y_sl),
    .chain_in  (chain_q),
    .mode      (mode_q),
    .s         (s_sl),
    .chain_out (chain_out)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    mode_d   = mode_q;
    chain_d  = chain_q;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          mode_d   = mode;
          // subtract runs as a + ~b + ~cin, so the chain holds the inverted borrow
          chain_d  = (mode == MODE_ADD) ? cin : ~cin;
          idx_d    = '0;
          result_d = '0;
          cout_d   = 1'b0;
          zero_d   = 1'b0;
          ovf_d    = 1'b0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        result_d[idx_q*CHUNK +: CHUNK] = s_sl;
        chain_d = chain_out;
        idx_d   = idx_q + IDXW'(1);
        if (last) begin
          idx_d   = '0;
          state_d = ST_DONE;
          cout_d  = (mode_q == MODE_ADD) ? chain_out : ~chain_out;
          zero_d  = (result_d == '0);
          ovf_d   = (result_d[MSB] != a_q[MSB]) &&
                    ((mode_q == MODE_ADD) ? (a_q[MSB] == b_q[MSB])
                                          : (a_q[MSB] != b_q[MSB]));
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= 1'b0;
      chain_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mode_q   <= mode_d;
      chain_q  <= chain_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign cout      = cout_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

endmodule
